// File: rtl/decode_queue_if.sv
// Fetch-to-decode record handshake for the decode queue.
// The slave modport is the queue itself; master is the fetch/decode side.
interface decode_queue_if #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [31:0]        in_instr;
    logic               in_exception;
    logic [CAUSE_W-1:0] in_ecause;
    logic [XLEN-1:0]    in_etval;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_npc;
    logic [31:0]        out_instr;
    logic               out_rvc;
    logic               out_exception;
    logic [CAUSE_W-1:0] out_ecause;
    logic [XLEN-1:0]    out_etval;

    modport slave (
        input  in_valid, in_pc, in_instr,
        input  in_exception, in_ecause, in_etval,
        output in_ready,
        output out_valid, out_pc, out_npc, out_instr,
        output out_rvc, out_exception, out_ecause, out_etval,
        input  out_ready
    );

    modport master (
        output in_valid, in_pc, in_instr,
        output in_exception, in_ecause, in_etval,
        input  in_ready,
        input  out_valid, out_pc, out_npc, out_instr,
        input  out_rvc, out_exception, out_ecause, out_etval,
        output out_ready
    );
endinterface

// File: rtl/decode_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of
// pc/instr/exception records with registered npc and optional bypass.
module decode_queue #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int CAUSE_W = 4,
    parameter int BYPASS  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    decode_queue_if.slave          q,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0]    pc_q    [DEPTH];
    logic [XLEN-1:0]    npc_q   [DEPTH];
    logic [31:0]        instr_q [DEPTH];
    logic               exc_q   [DEPTH];
    logic [CAUSE_W-1:0] cause_q [DEPTH];
    logic [XLEN-1:0]    etval_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic            byp;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            rd_en;
    logic [XLEN-1:0] in_npc;
    logic [XLEN-1:0] sel_npc;
    logic [31:0]     sel_instr;

    assign in_npc = q.in_pc
                  + ((q.in_instr[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2));

    always_comb begin
        byp        = (BYPASS != 0) && (count_q == '0);
        q.in_ready = rst & ~flush & (count_q < DEPTH_C);
        q.out_valid = rst & ~flush
                    & (byp ? q.in_valid : (count_q != '0));
        push  = q.in_valid & q.in_ready;
        pop   = q.out_valid & q.out_ready;
        // A bypassed record that decode takes at once never lands in storage
        wr_en = push & ~(byp & q.out_ready);
        rd_en = pop & ~byp;
    end

    always_comb begin
        if (byp) begin
            q.out_pc        = q.in_pc;
            sel_npc         = in_npc;
            sel_instr       = q.in_instr;
            q.out_exception = q.in_exception;
            q.out_ecause    = q.in_ecause;
            q.out_etval     = q.in_etval;
        end else begin
            q.out_pc        = pc_q[rptr_q];
            sel_npc         = npc_q[rptr_q];
            sel_instr       = instr_q[rptr_q];
            q.out_exception = exc_q[rptr_q];
            q.out_ecause    = cause_q[rptr_q];
            q.out_etval     = etval_q[rptr_q];
        end
        q.out_instr = sel_instr;
        q.out_rvc   = (sel_instr[1:0] != 2'b11);
        q.out_npc   = q.out_valid ? sel_npc : '0;
    end

    always_comb begin
        wptr_d  = wptr_q + AW'(wr_en);
        rptr_d  = rptr_q + AW'(rd_en);
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                npc_q[i]   <= '0;
                instr_q[i] <= '0;
                exc_q[i]   <= 1'b0;
                cause_q[i] <= '0;
                etval_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (wr_en) begin
                pc_q[wptr_q]    <= q.in_pc;
                npc_q[wptr_q]   <= in_npc;
                instr_q[wptr_q] <= q.in_instr;
                exc_q[wptr_q]   <= q.in_exception;
                cause_q[wptr_q] <= q.in_ecause;
                etval_q[wptr_q] <= q.in_etval;
            end
        end
    end

    assign count = count_q;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: table vectors on a BYPASS=0 queue
// plus hand sequences for reset, exceptions and a BYPASS=1 queue.
module tb_decode_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fl_a = 1'b0;
    logic       fl_b = 1'b0;
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(32), .CAUSE_W(4)) a_if ();
    decode_queue_if #(.XLEN(32), .CAUSE_W(4)) b_if ();

    decode_queue #(.XLEN(32), .DEPTH(4), .CAUSE_W(4), .BYPASS(0)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (fl_a),
        .q     (a_if.slave),
        .count (cnt_a)
    );

    decode_queue #(.XLEN(32), .DEPTH(4), .CAUSE_W(4), .BYPASS(1)) u_byp (
        .clk   (clk),
        .rst   (rst),
        .flush (fl_b),
        .q     (b_if.slave),
        .count (cnt_b)
    );

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] epc;
        logic [31:0] enpc;
        logic        ervc;
        logic [2:0]  ecnt;
        logic        eir;
    } vec_t;

    vec_t vt[28];

    function automatic vec_t mk(
        logic iv, logic [31:0] pc, logic [31:0] instr,
        logic ordy, logic fl, logic ov, logic [31:0] epc,
        logic [31:0] enpc, logic ervc, logic [2:0] ecnt, logic eir
    );
        vec_t v;
        v.iv = iv; v.pc = pc; v.instr = instr;
        v.ordy = ordy; v.fl = fl; v.ov = ov;
        v.epc = epc; v.enpc = enpc; v.ervc = ervc;
        v.ecnt = ecnt; v.eir = eir;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.in_valid = 0; a_if.in_pc = 0; a_if.in_instr = 0;
        a_if.in_exception = 0; a_if.in_ecause = 0; a_if.in_etval = 0;
        a_if.out_ready = 0;
        b_if.in_valid = 0; b_if.in_pc = 0; b_if.in_instr = 32'h13;
        b_if.in_exception = 0; b_if.in_ecause = 0; b_if.in_etval = 0;
        b_if.out_ready = 0;

        // Vectors: inputs for one cycle and outputs expected before its edge
        vt[0]  = mk(1, 32'h100, 32'h00A00093, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[1]  = mk(0, 0, 32'h13, 0, 0, 1, 32'h100, 32'h104, 0, 1, 1);
        vt[2]  = mk(0, 0, 32'h13, 1, 0, 1, 32'h100, 32'h104, 0, 1, 1);
        vt[3]  = mk(1, 32'h200, 32'h4505, 1, 0, 0, 0, 0, 0, 0, 1);
        vt[4]  = mk(0, 0, 32'h13, 1, 0, 1, 32'h200, 32'h202, 1, 1, 1);
        vt[5]  = mk(0, 0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[6]  = mk(1, 32'h0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[7]  = mk(1, 32'h4, 32'h13, 0, 0, 1, 32'h0, 32'h4, 0, 1, 1);
        vt[8]  = mk(1, 32'h8, 32'h13, 0, 0, 1, 32'h0, 32'h4, 0, 2, 1);
        vt[9]  = mk(1, 32'hC, 32'h13, 0, 0, 1, 32'h0, 32'h4, 0, 3, 1);
        vt[10] = mk(1, 32'h10, 32'h13, 0, 0, 1, 32'h0, 32'h4, 0, 4, 0);
        vt[11] = mk(1, 32'h10, 32'h13, 1, 0, 1, 32'h0, 32'h4, 0, 4, 0);
        vt[12] = mk(1, 32'h10, 32'h13, 1, 0, 1, 32'h4, 32'h8, 0, 3, 1);
        vt[13] = mk(0, 0, 32'h13, 1, 0, 1, 32'h8, 32'hC, 0, 3, 1);
        vt[14] = mk(0, 0, 32'h13, 1, 0, 1, 32'hC, 32'h10, 0, 2, 1);
        vt[15] = mk(0, 0, 32'h13, 1, 0, 1, 32'h10, 32'h14, 0, 1, 1);
        vt[16] = mk(0, 0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[17] = mk(1, 32'h20, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[18] = mk(1, 32'h24, 32'h13, 0, 0, 1, 32'h20, 32'h24, 0, 1, 1);
        vt[19] = mk(1, 32'h28, 32'h13, 0, 0, 1, 32'h20, 32'h24, 0, 2, 1);
        vt[20] = mk(1, 32'h2C, 32'h13, 1, 1, 0, 0, 0, 0, 3, 0);
        vt[21] = mk(0, 0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[22] = mk(1, 32'h300, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[23] = mk(0, 0, 32'h13, 1, 0, 1, 32'h300, 32'h304, 0, 1, 1);
        vt[24] = mk(0, 0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[25] = mk(1, 32'hFFFFFFFE, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[26] = mk(0, 0, 32'h13, 1, 0, 1, 32'hFFFFFFFE, 32'h2, 0, 1, 1);
        vt[27] = mk(0, 0, 32'h13, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset held low: both sides closed
        step();
        step();
        chk("rst.in_ready", a_if.in_ready, 0);
        chk("rst.out_valid", a_if.out_valid, 0);
        chk("rst.byp_valid", b_if.out_valid, 0);
        rst = 1;
        #1;
        chk("rst.count", cnt_a, 0);
        chk("rst.out_pc", a_if.out_pc, 0);
        chk("rst.out_npc", a_if.out_npc, 0);
        chk("rst.out_instr", a_if.out_instr, 0);
        chk("rst.out_rvc", a_if.out_rvc, 1);
        chk("rst.out_exc", a_if.out_exception, 0);
        chk("rst.out_ecause", a_if.out_ecause, 0);
        chk("rst.out_etval", a_if.out_etval, 0);
        chk("rst.in_ready1", a_if.in_ready, 1);

        for (int i = 0; i < 28; i++) begin
            a_if.in_valid  = vt[i].iv;
            a_if.in_pc     = vt[i].pc;
            a_if.in_instr  = vt[i].instr;
            a_if.out_ready = vt[i].ordy;
            fl_a           = vt[i].fl;
            #1;
            chk($sformatf("v%0d.out_valid", i), a_if.out_valid, vt[i].ov);
            chk($sformatf("v%0d.count", i), cnt_a, vt[i].ecnt);
            chk($sformatf("v%0d.in_ready", i), a_if.in_ready, vt[i].eir);
            if (vt[i].ov) begin
                chk($sformatf("v%0d.out_pc", i), a_if.out_pc, vt[i].epc);
                chk($sformatf("v%0d.out_npc", i), a_if.out_npc, vt[i].enpc);
                chk($sformatf("v%0d.out_rvc", i), a_if.out_rvc, vt[i].ervc);
            end
            step();
        end
        a_if.in_valid = 0; a_if.out_ready = 0; fl_a = 0;

        // Exception record passes through untouched
        a_if.in_valid = 1; a_if.in_pc = 32'h600; a_if.in_instr = 32'h13;
        a_if.in_exception = 1; a_if.in_ecause = 4'h1;
        a_if.in_etval = 32'h500;
        step();
        a_if.in_valid = 0; a_if.in_exception = 0;
        a_if.in_ecause = 0; a_if.in_etval = 0;
        #1;
        chk("exc.out_valid", a_if.out_valid, 1);
        chk("exc.out_pc", a_if.out_pc, 32'h600);
        chk("exc.out_instr", a_if.out_instr, 32'h13);
        chk("exc.out_exc", a_if.out_exception, 1);
        chk("exc.out_ecause", a_if.out_ecause, 4'h1);
        chk("exc.out_etval", a_if.out_etval, 32'h500);
        a_if.out_ready = 1;
        step();
        a_if.out_ready = 0;
        #1;
        chk("exc.count", cnt_a, 0);

        // Reset in the middle of traffic drops everything
        a_if.in_valid = 1; a_if.in_pc = 32'h700;
        step();
        a_if.in_pc = 32'h704;
        step();
        a_if.in_valid = 0;
        #1;
        chk("mrst.pre_count", cnt_a, 2);
        rst = 0;
        #1;
        chk("mrst.in_ready", a_if.in_ready, 0);
        chk("mrst.out_valid", a_if.out_valid, 0);
        step();
        rst = 1;
        #1;
        chk("mrst.count", cnt_a, 0);
        chk("mrst.out_valid1", a_if.out_valid, 0);
        step();
        chk("mrst.out_valid2", a_if.out_valid, 0);

        // Bypass: consumed in the same cycle, never stored
        b_if.in_valid = 1; b_if.in_pc = 32'h400; b_if.in_instr = 32'h13;
        b_if.out_ready = 1;
        #1;
        chk("byp.out_valid", b_if.out_valid, 1);
        chk("byp.out_pc", b_if.out_pc, 32'h400);
        chk("byp.out_npc", b_if.out_npc, 32'h404);
        chk("byp.count", cnt_b, 0);
        step();
        b_if.in_valid = 0;
        #1;
        chk("byp.count_after", cnt_b, 0);
        chk("byp.valid_after", b_if.out_valid, 0);

        // Bypass with decode stalled: stored and held
        b_if.in_valid = 1; b_if.out_ready = 0;
        #1;
        chk("bst.out_valid", b_if.out_valid, 1);
        chk("bst.out_pc", b_if.out_pc, 32'h400);
        step();
        b_if.in_valid = 0; b_if.in_pc = 32'h0;
        #1;
        chk("bst.count", cnt_b, 1);
        chk("bst.held_valid", b_if.out_valid, 1);
        chk("bst.held_pc", b_if.out_pc, 32'h400);
        chk("bst.held_npc", b_if.out_npc, 32'h404);
        b_if.out_ready = 1;
        step();
        b_if.out_ready = 0;
        #1;
        chk("bst.count_end", cnt_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised instruction buffer that sits between the fetch stage and the decode stage.
- It decouples fetch from decode stalls (division, CSR write, multicycle bit-manipulation) with a DEPTH-entry FIFO of fetched pc/instr/exception records.
- It pre-computes npc and the compressed-instruction flag so decode sees them registered.
- It supports pipeline clear (jump/exception/mret) and an optional zero-latency bypass when empty.

Parameters:
- XLEN, 32: width of pc, npc and etval.
- DEPTH, 4: number of entries; power of two, >= 2.
- CAUSE_W, 4: width of the exception cause field.
- BYPASS, 0: 1 enables a combinational path from in_* to out_* when the queue is empty.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  pipeline clear (jump | exception | mret | execute clear).
- in_valid  input  1  fetch record valid.
- in_ready  output  1  queue accepts the record this cycle.
- in_pc  input  XLEN  fetch pc.
- in_instr  input  32  raw instruction; bits [31:16] are don't-care for RVC.
- in_exception  input  1  fetch exception.
- in_ecause  input  CAUSE_W  fetch exception cause.
- in_etval  input  XLEN  fetch exception value.
- out_valid  output  1  head record valid.
- out_ready  input  1  decode consumes the head (not stalled).
- out_pc  output  XLEN  head pc.
- out_npc  output  XLEN  head pc + 2 or pc + 4.
- out_instr  output  32  head instruction.
- out_rvc  output  1  head is compressed (instr[1:0] != 2'b11).
- out_exception  output  1  head exception.
- out_ecause  output  CAUSE_W  head cause.
- out_etval  output  XLEN  head etval.
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst==0 at posedge clk):
  - Pointers and count go to 0; all storage entries are cleared to 0.
  - While rst==0: in_ready=0, out_valid=0.
  - After reset: out_pc, out_npc, out_instr, out_ecause and out_etval are 0; out_exception=0; out_rvc=1, because instr 0 is decoded as compressed and out_npc is therefore 0+2=2 only when valid; otherwise it is forced to 0.
- Reset mid-operation discards all entries; nothing is emitted on the cycle after reset.
- Push/pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = rst & ~flush & (count < DEPTH). in_ready has no combinational dependence on out_ready; a full queue refuses input even if popped the same cycle.
  - Write pointer and read pointer each wrap modulo DEPTH. count += push - pop; simultaneous push and pop leaves count unchanged.
- Latency:
  - BYPASS=0: a pushed record appears at out_* on the next cycle (1 cycle). out_* come from a combinational read of the head entry.
  - BYPASS=1 and count==0: out_valid = in_valid and out_* derive from in_*. If out_ready=1 the record is consumed with no storage write and count stays 0. If out_ready=0 the record is stored and presented from storage next cycle.
- npc = (pc + (instr[1:0]==2'b11 ? 4 : 2)) mod 2^XLEN; wrap-around is silent. npc is computed at push and stored, except on the bypass path where it is combinational.
- Exception records are queued like any other record; the queue never interprets cause, etval or instr validity.
- Flush:
  - When flush=1: pointers and count reset to 0 at the clock edge, and out_valid=0 and in_ready=0 combinationally in that cycle.
  - A concurrent in_valid is dropped and not counted. A concurrent out_ready produces no pop.
  - Storage contents are left stale; they are not observable because out_valid=0.
  - Flush has priority over push and pop; reset has priority over flush.
- Empty, BYPASS=0: out_valid=0; out_* hold the stale head entry and are don't-care.
- Full: in_ready=0 and fetch must hold its record stable until accepted.
- No record is ever duplicated or reordered; output order equals acceptance order.

Test Plan:
- Reset, then push pc=0x100 instr=0x00A00093 (addi) → next cycle: out_valid=1, out_pc=0x100, out_npc=0x104, out_rvc=0, count=1.
- Push pc=0x200 instr=0x4505 (c.li) with out_ready=1 continuously, BYPASS=0 → 1-cycle latency, out_npc=0x202, out_rvc=1, count returns to 0.
- DEPTH=4, out_ready=0, push 5 records pc=0x0,0x4,0x8,0xC,0x10 → count=4, in_ready=0 from the 5th attempt. Then out_ready=1 → pops 0x0..0xC in order, and 0x10 is accepted once count<4.
- Fill 3 entries, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, no pop observed. Then push pc=0x300 → out_pc=0x300.
- BYPASS=1, empty queue, in_valid=1 pc=0x400 with out_ready=1 → same-cycle out_valid=1, out_pc=0x400, count stays 0. Repeat with out_ready=0 → count=1 next cycle and out_pc=0x400 held.
- pc=0xFFFFFFFE, instr=0x00000013 → out_npc=0x00000002 (wrap). Push in_exception=1, ecause=1, etval=0x500 → the fields are reproduced unchanged at the output.
